// File: rtl/systolic_row_feeder_if.sv
// systolic_row_feeder_if: operand column stream in, skewed per-row array bus out
interface systolic_row_feeder_if #(parameter int IP_size = 8, parameter int ROWS = 4);
  logic s_valid;
  logic s_ready;
  logic [ROWS*IP_size-1:0] s_x;
  logic [ROWS*IP_size-1:0] x_out;
  logic [ROWS-1:0] en_out;
  logic [ROWS-1:0] clr_out;
  modport master (output s_valid, s_x, input s_ready, x_out, en_out, clr_out);
  modport slave (input s_valid, s_x, output s_ready, x_out, en_out, clr_out);
endinterface

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: skews operand columns onto array rows with en/clr sideband and tile_done; FEEDER_STALL_CNT_EN adds the stall counter
module systolic_row_feeder #(
  parameter int IP_size = 8,
  parameter int ROWS = 4,
  parameter int KW = 16,
  parameter int DONE_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [KW-1:0] k_len,
  output logic busy,
  output logic cfg_err,
  output logic tile_done,
  output logic [15:0] stall_cnt,
  systolic_row_feeder_if.slave s
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [KW-1:0] k_reg, beat_cnt, drain_cnt;
  logic acc, last, go;
  assign s.s_ready = state == STREAM;
  assign acc = s.s_valid && s.s_ready;
  assign last = acc && beat_cnt == k_reg - 1'b1;
  assign go = state == IDLE && start;
  assign busy = state != IDLE;
  assign tile_done = state == DRAIN && drain_cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (go && k_len != '0 ? STREAM : IDLE) :
              state == STREAM ? (last ? DRAIN : STREAM) :
                                (tile_done ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_err <= 1'b0;
      k_reg <= '0;
      beat_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      cfg_err <= go && k_len == '0;
      if (go) begin
        k_reg <= k_len;
        beat_cnt <= '0;
      end
      if (acc && !last) beat_cnt <= beat_cnt + 1'b1;
      drain_cnt <= last ? KW'(ROWS - 1 + DONE_LAT) :
                   (state == DRAIN && drain_cnt != '0) ? drain_cnt - 1'b1 : drain_cnt;
    end
  // row r is its slice of the row-0 stage followed by r more stages
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [IP_size-1:0] xs [r+1];
    logic [r:0] es, cs;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) xs[i] <= '0;
        es <= '0;
        cs <= '0;
      end else begin
        xs[0] <= acc ? s.s_x[r*IP_size +: IP_size] : '0;
        es[0] <= acc;
        cs[0] <= acc && beat_cnt == '0;
        for (int i = 1; i <= r; i++) begin
          xs[i] <= xs[i-1];
          es[i] <= es[i-1];
          cs[i] <= cs[i-1];
        end
      end
    assign s.x_out[r*IP_size +: IP_size] = xs[r];
    assign s.en_out[r] = es[r];
    assign s.clr_out[r] = cs[r];
  end
`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (go) stall_cnt <= '0;
    else if (state == STREAM && !s.s_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_systolic_row_feeder.sv
// tb_systolic_row_feeder: scoreboard bench for the row feeder skew, sideband and tile sequencing
module tb_systolic_row_feeder;
  localparam int W = 8;
  localparam int R = 4;
  localparam int DL = 4;
  localparam int HUGE = 32'h3fffffff;
  logic clk = 0, rst_n = 1, start = 0;
  logic [15:0] k_len = '0;
  logic busy, cfg_err, tile_done;
  logic [15:0] stall_cnt;
  systolic_row_feeder_if #(.IP_size(W), .ROWS(R)) f();
  systolic_row_feeder #(.IP_size(W), .ROWS(R), .KW(16), .DONE_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .cfg_err(cfg_err), .tile_done(tile_done), .stall_cnt(stall_cnt), .s(f));
  typedef struct {int due; logic [W-1:0] x; logic clr;} ent_t;
  ent_t q [R][$];
  int vec = 0, err = 0, cyc = 0, busy_from = HUGE, done_at = -1, cfg_at = -1;
  always #5 clk = ~clk;

  task automatic tick();
    ent_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int r = 0; r < R; r++) begin
      vec++;
      if (f.en_out[r]) begin
        if (q[r].size() == 0) begin
          err++;
          $display("FAIL row%0d_unexpected_beat cyc=%0d x=%0d", r, cyc, f.x_out[r*W +: W]);
        end else begin
          e = q[r].pop_front();
          if (e.due !== cyc || f.x_out[r*W +: W] !== e.x || f.clr_out[r] !== e.clr) begin
            err++;
            $display("FAIL row%0d_beat got cyc=%0d x=%0d clr=%b expected cyc=%0d x=%0d clr=%b",
                     r, cyc, f.x_out[r*W +: W], f.clr_out[r], e.due, e.x, e.clr);
          end
        end
      end else if (f.x_out[r*W +: W] !== '0 || f.clr_out[r] !== 1'b0) begin
        err++;
        $display("FAIL row%0d_bubble cyc=%0d got x=%0d clr=%b expected 0/0", r, cyc, f.x_out[r*W +: W], f.clr_out[r]);
      end
    end
    vec++;
    if (tile_done !== (cyc == done_at)) begin
      err++;
      $display("FAIL tile_done cyc=%0d got %b expected %b", cyc, tile_done, cyc == done_at);
    end
    vec++;
    if (busy !== (cyc >= busy_from && cyc <= done_at)) begin
      err++;
      $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, cyc >= busy_from && cyc <= done_at);
    end
    vec++;
    if (cfg_err !== (cyc == cfg_at)) begin
      err++;
      $display("FAIL cfg_err cyc=%0d got %b expected %b", cyc, cfg_err, cyc == cfg_at);
    end
  endtask

  task automatic flush_check();
    for (int r = 0; r < R; r++) begin
      vec++;
      if (q[r].size() != 0) begin
        err++;
        $display("FAIL row%0d_missing_beats got 0 expected %0d more", r, q[r].size());
      end
      q[r].delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    vec++;
    if ({busy, cfg_err, tile_done, stall_cnt, f.s_ready, f.x_out, f.en_out, f.clr_out} !== '0) begin
      err++;
      $display("FAIL %s got busy=%b cfg_err=%b done=%b stall=%0d ready=%b x=%h en=%b clr=%b expected all 0",
               name, busy, cfg_err, tile_done, stall_cnt, f.s_ready, f.x_out, f.en_out, f.clr_out);
    end
  endtask

  task automatic run_tile(input int k, input logic [31:0] gmask, input logic [7:0] base, input bit extra);
    int acc = 0;
    logic v;
    start = 1;
    k_len = 16'(k);
    busy_from = cyc + 1;
    done_at = HUGE;
    tick();
    start = 0;
    for (int i = 0; i < 64 && acc < k; i++) begin
      v = (i >= 32) || !gmask[i];
      vec++;
      if (f.s_ready !== 1'b1) begin
        err++;
        $display("FAIL s_ready_stream cyc=%0d got %b expected 1", cyc, f.s_ready);
      end
      f.s_valid = v;
      for (int r = 0; r < R; r++)
        f.s_x[r*W +: W] = v ? W'(base + 10 + r + 20 * acc) : W'($urandom);
      if (v) begin
        for (int r = 0; r < R; r++) q[r].push_back('{cyc + 1 + r, f.s_x[r*W +: W], acc == 0});
        acc++;
        if (acc == k) done_at = cyc + 1 + R - 1 + DL;
      end
      if (extra && i == 1) begin
        start = 1;
        k_len = 16'd5;
      end
      tick();
      start = 0;
    end
    f.s_valid = 0;
    for (int j = 0; j < R + DL + 1; j++) begin
      vec++;
      if (f.s_ready !== 1'b0) begin
        err++;
        $display("FAIL s_ready_drain cyc=%0d got %b expected 0", cyc, f.s_ready);
      end
      f.s_x = $urandom;
      tick();
    end
    flush_check();
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1 check_all_zero("reset_state");
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    run_tile(3, 32'h0, 8'h00, 0);
  endtask

  task automatic test_bubble();
    run_tile(3, 32'h2, 8'hF0, 0);
  endtask

  task automatic test_cfg_err();
    busy_from = HUGE;
    done_at = -1;
    start = 1;
    k_len = 0;
    cfg_at = cyc + 1;
    tick();
    start = 0;
    for (int j = 0; j < 3; j++) begin
      vec++;
      if (f.s_ready !== 1'b0) begin
        err++;
        $display("FAIL cfg_err_s_ready cyc=%0d got %b expected 0", cyc, f.s_ready);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    run_tile(3, 32'h0, 8'h40, 1);
  endtask

  task automatic test_stall();
    logic [15:0] exp5;
`ifdef FEEDER_STALL_CNT_EN
    exp5 = 16'd5;
`else
    exp5 = 16'd0;
`endif
    run_tile(2, 32'h1F, 8'h55, 0);
    vec++;
    if (stall_cnt !== exp5) begin
      err++;
      $display("FAIL stall_cnt_count got %0d expected %0d", stall_cnt, exp5);
    end
    run_tile(1, 32'h0, 8'h00, 0);
    vec++;
    if (stall_cnt !== 16'd0) begin
      err++;
      $display("FAIL stall_cnt_clear got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    start = 1;
    k_len = 16'd5;
    busy_from = cyc + 1;
    done_at = HUGE;
    tick();
    start = 0;
    for (int b = 0; b < 2; b++) begin
      f.s_valid = 1;
      for (int r = 0; r < R; r++) f.s_x[r*W +: W] = W'(100 + r + 20 * b);
      for (int r = 0; r < R; r++) q[r].push_back('{cyc + 1 + r, f.s_x[r*W +: W], b == 0});
      tick();
    end
    #2 rst_n = 0;
    #1 check_all_zero("async_reset");
    for (int r = 0; r < R; r++) q[r].delete();
    busy_from = HUGE;
    done_at = -1;
    f.s_valid = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    run_tile(4, 32'h4, 8'h80, 0);
  endtask

  initial begin
    f.s_valid = 0;
    f.s_x = '0;
    test_reset();
    test_basic();
    test_bubble();
    test_cfg_err();
    test_start_ignored();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
- West-edge transmitter for the systolic MAC array.
- Accepts one column of operands per beat over a valid/ready stream and presents row r's operand with an r-cycle skew.
- Generates the en/clr sideband that each array row consumes: clr marks the first beat of a tile, en marks every valid beat.
- Counts the reduction length, drains the pipeline, and pulses tile_done when the last row's accumulators are final.

Parameters:
- IP_size, 8: operand width in bits, signed.
- ROWS, 4: number of array rows fed; at least 1.
- KW, 16: width of the k_len tile-length input.
- DONE_LAT, 4: cycles from the last row presenting its last beat to its accumulator being final. Integrator sets this to MAC depth plus column skew.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle tile start request; honoured only in IDLE.
- k_len  in  KW  beats in the tile, unsigned; sampled when start is honoured.
- busy  out  1  high in STREAM and DRAIN.
- cfg_err  out  1  one-cycle pulse when start is honoured with k_len==0.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  feeder accepts a beat.
- s_x  in  ROWS*IP_size  operand column; row r is slice [r*IP_size +: IP_size].
- x_out  out  ROWS*IP_size  skewed operands to array row inputs.
- en_out  out  ROWS  per-row beat valid.
- clr_out  out  ROWS  per-row first-beat flag; only ever high together with en_out.
- tile_done  out  1  one-cycle pulse when the tile is complete.
- stall_cnt  out  16  upstream stall count (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): state IDLE, all delay lines and counters cleared. Every output is 0: busy, cfg_err, s_ready, x_out, en_out, clr_out, tile_done, stall_cnt.
- Handshake: beat accepted on an edge where s_valid && s_ready.
  - s_ready is a registered state decode: 1 only in STREAM, with no combinational path from s_valid.
  - s_x is don't-care when not accepted.
- State IDLE:
  - start && k_len!=0: latch k_len, clear beat counter, go to STREAM.
  - start && k_len==0: pulse cfg_err next cycle, stay in IDLE.
- State STREAM:
  - Each accepted beat loads the row-0 output register with x=s_x, en=1, clr=(beat counter==0), then increments the beat counter.
  - Edge with no accepted beat loads a bubble: x=0, en=0, clr=0. Skew alignment is preserved.
  - Accepting beat k_len-1: go to DRAIN and load the drain counter with ROWS-1+DONE_LAT.
- State DRAIN:
  - s_ready=0; bubbles are inserted; drain counter decrements each edge.
  - Drain counter==0: tile_done=1 for exactly that cycle; next edge returns to IDLE.
- Skew:
  - Row r outputs are row-r slices of the row-0 output register passed through r additional registers.
  - A beat accepted at edge E appears on row r after edge E+r.
  - Rows never reorder, and the per-row en/clr/x stay aligned.
- Timing:
  - busy is high from the cycle after start is honoured through the tile_done cycle inclusive.
  - start is ignored while busy; no error is flagged.
- Arithmetic: beat and drain counters are KW wide, and the beat counter never wraps because it stops at k_len-1. There is no arithmetic on operand data; it passes bit-exact.
- Async reset mid-tile: everything clears immediately; a partial tile is abandoned and no tile_done is issued.

Optional Feature:
- Macro FEEDER_STALL_CNT_EN.
- When defined:
  - stall_cnt counts STREAM cycles with s_valid==0.
  - It saturates at 16'hFFFF, clears when start is honoured, and holds its value otherwise.
- When not defined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- ROWS=4, DONE_LAT=4, start at edge E0 with k_len=3, beats accepted at E1-E3 with row r = 10+r:
  - en_out[0] is high after E1-E3 and en_out[3] after E4-E6.
  - clr_out[0] is high only after E1; clr_out[3] only after E4.
  - x_out[3] = 13 after E4.
  - tile_done pulses exactly once, after E10.
- Same tile with s_valid low at E2:
  - Bubble appears on row 0 after E2 and on row 3 after E5.
  - Four en pulses total per row minus one bubble, i.e. 3 beats per row.
  - tile_done is one cycle later than in the first scenario.
- start with k_len=0: cfg_err pulses once, busy stays 0, s_ready stays 0.
- start asserted during STREAM with k_len=5:
  - The running tile is unaffected and finishes with its original 3 beats.
  - Only one tile_done occurs.
- rst_n low mid-STREAM: all outputs read 0 asynchronously; after release, a new tile runs normally from a clean state.
- FEEDER_STALL_CNT_EN defined, 5 idle STREAM cycles: stall_cnt=5, and it reads 0 after the next start.
